// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared control-transfer and fetch-state encodings
package fetch_unit_pkg;

    localparam logic [1:0] CP_SEQ  = 2'b00;
    localparam logic [1:0] CP_REG  = 2'b01;
    localparam logic [1:0] CP_JUMP = 2'b10;
    localparam logic [1:0] CP_BR   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        WAIT  = 2'b10,
        READY = 2'b11
    } fetch_state_e;

    // Word-scaled, sign-extended branch displacement from a 16-bit immediate.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// rtl/fetch_unit_next_pc_calc.sv - combinational next-PC target selection
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [1:0]  cp_type,
    input  logic        enbranch,
    input  logic [31:0] rs_val,
    output logic [31:0] target,
    output logic        misalign
);

    logic unused_opc;
    assign unused_opc = ^instr[31:26];

    always_comb begin
        target   = pc_plus4;
        misalign = 1'b0;
        case (cp_type)
            CP_SEQ:  target = pc_plus4;
            CP_REG: begin
                target   = {rs_val[31:2], 2'b00};
                misalign = |rs_val[1:0];
            end
            CP_JUMP: target = {pc_plus4[31:28], instr[25:0], 2'b00};
            CP_BR:   target = enbranch ? (pc_plus4 + br_offset(instr[15:0])) : pc_plus4;
            default: target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, instruction register and fetch request sequencing
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        write_pc,
    input  logic [1:0]  cp_type,
    input  logic        enbranch,
    input  logic [31:0] rs_val,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [5:0]  opecode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic        pc_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  target;
    logic         misalign;
    logic         pc_load;
    logic         instr_load;
    logic         err_set;

    next_pc_calc u_next_pc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .cp_type  (cp_type),
        .enbranch (enbranch),
        .rs_val   (rs_val),
        .target   (target),
        .misalign (misalign)
    );

    assign pc_plus4    = pc + 32'd4;
    assign imem_addr   = pc;
    assign opecode     = instr[31:26];
    assign funct       = instr[5:0];
    // Request and valid come from registered state only, never from inputs.
    assign imem_req    = (state_q == REQ);
    assign instr_valid = (state_q == READY);

    assign pc_load    = (state_q == READY) && write_pc;
    assign instr_load = (state_q == WAIT) && imem_valid;
    assign err_set    = (write_pc && (state_q != READY)) ||
                        (imem_valid && (state_q != WAIT)) ||
                        (pc_load && misalign);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     state_d = WAIT;
            WAIT:    if (imem_valid) state_d = READY;
            READY:   if (write_pc) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            pc      <= RESET_PC;
            instr   <= 32'h0;
            pc_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pc_load) pc <= target;
            // Old word stays visible until the new one lands.
            if (instr_load) instr <= imem_rdata;
            if (err_set) pc_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [1:0] SEQ = 2'b00;
    localparam logic [1:0] REG = 2'b01;
    localparam logic [1:0] JMP = 2'b10;
    localparam logic [1:0] BR  = 2'b11;

    logic        clk = 1'b0;
    logic        rstn;
    logic        write_pc;
    logic [1:0]  cp_type;
    logic        enbranch;
    logic [31:0] rs_val;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [5:0]  opecode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic        pc_err;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .write_pc    (write_pc),
        .cp_type     (cp_type),
        .enbranch    (enbranch),
        .rs_val      (rs_val),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .opecode     (opecode),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc_err      (pc_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        write_pc   = 1'b0;
        cp_type    = SEQ;
        enbranch   = 1'b0;
        rs_val     = 32'h0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        step();
        step();
        rstn = 1'b1;
    endtask

    // Serve the pending fetch with the given latency (cycles from request to valid).
    task automatic fetch(input string tag, input logic [31:0] word, input int lat,
                         input logic [31:0] exp_addr);
        int n = 0;
        while (!imem_req && n < 8) begin
            step();
            n++;
        end
        check({tag, "_req"}, {31'h0, imem_req}, 32'h1);
        check({tag, "_addr"}, imem_addr, exp_addr);
        step();
        repeat (lat - 1) step();
        imem_valid = 1'b1;
        imem_rdata = word;
        step();
        imem_valid = 1'b0;
        check({tag, "_ivalid"}, {31'h0, instr_valid}, 32'h1);
        check({tag, "_instr"}, instr, word);
    endtask

    task automatic advance(input string tag, input logic [1:0] cp, input logic en,
                           input logic [31:0] rs, input logic [31:0] exp_pc);
        write_pc = 1'b1;
        cp_type  = cp;
        enbranch = en;
        rs_val   = rs;
        step();
        write_pc = 1'b0;
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_req"}, {31'h0, imem_req}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        check("rst_instr", instr, 32'h0);
        check("rst_opc", {26'h0, opecode}, 32'h0);
        check("rst_funct", {26'h0, funct}, 32'h0);
        check("rst_ivalid", {31'h0, instr_valid}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_err", {31'h0, pc_err}, 32'h0);

        // First fetch: request one edge after release, latency 1.
        step();
        check("f0_req", {31'h0, imem_req}, 32'h1);
        check("f0_addr", imem_addr, 32'h0);
        step();
        check("f0_req_off", {31'h0, imem_req}, 32'h0);
        check("f0_iv_early", {31'h0, instr_valid}, 32'h0);
        imem_valid = 1'b1;
        imem_rdata = 32'h2008_0005;
        step();
        imem_valid = 1'b0;
        check("f0_ivalid", {31'h0, instr_valid}, 32'h1);
        check("f0_opc", {26'h0, opecode}, 32'h0000_0008);
        check("f0_funct", {26'h0, funct}, 32'h0000_0005);

        advance("seq4", SEQ, 1'b0, 32'h0, 32'h4);
        fetch("f4", 32'h0800_0040, 1, 32'h4);
        advance("jmp100", JMP, 1'b0, 32'h0, 32'h100);
        fetch("f100", 32'h0, 1, 32'h100);
        advance("seq104", SEQ, 1'b0, 32'h0, 32'h104);
        fetch("f104", 32'h0, 1, 32'h104);

        advance("rjtop", REG, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        check("top_pc4", pc_plus4, 32'h0);
        fetch("ftop", 32'h0, 1, 32'hFFFF_FFFC);
        advance("wrap", SEQ, 1'b0, 32'h0, 32'h0);
        fetch("fwrap", 32'h0, 1, 32'h0);

        advance("rj200a", REG, 1'b0, 32'h200, 32'h200);
        fetch("f200a", 32'h1000_FFFE, 1, 32'h200);
        advance("br_t", BR, 1'b1, 32'h0, 32'h1FC);
        fetch("f1fc", 32'h0, 1, 32'h1FC);
        advance("rj200b", REG, 1'b0, 32'h200, 32'h200);
        fetch("f200b", 32'h1000_FFFE, 1, 32'h200);
        advance("br_nt", BR, 1'b0, 32'h0, 32'h204);
        fetch("f204", 32'h0, 1, 32'h204);

        advance("rjhi", REG, 1'b0, 32'h1000_0040, 32'h1000_0040);
        fetch("fhi", 32'h0800_0010, 1, 32'h1000_0040);
        advance("jmphi", JMP, 1'b0, 32'h0, 32'h1000_0040);
        check("jmp_err", {31'h0, pc_err}, 32'h0);
        fetch("fjmp", 32'h0, 1, 32'h1000_0040);
        advance("rjmis", REG, 1'b0, 32'h123, 32'h120);
        check("mis_err", {31'h0, pc_err}, 32'h1);
        fetch("fmis", 32'h0, 1, 32'h120);

        // Latency 5 with write_pc pulses during WAIT.
        do_reset();
        check("l5_err0", {31'h0, pc_err}, 32'h0);
        step();
        check("l5_req", {31'h0, imem_req}, 32'h1);
        step();
        for (int i = 0; i < 4; i++) begin
            write_pc = (i % 2 == 0);
            step();
        end
        write_pc = 1'b0;
        check("l5_pc", pc, 32'h0);
        check("l5_iv_early", {31'h0, instr_valid}, 32'h0);
        imem_valid = 1'b1;
        imem_rdata = 32'hA5A5_0001;
        step();
        imem_valid = 1'b0;
        check("l5_ivalid", {31'h0, instr_valid}, 32'h1);
        check("l5_instr", instr, 32'hA5A5_0001);
        check("l5_pc_hold", pc, 32'h0);
        check("l5_err", {31'h0, pc_err}, 32'h1);

        // Reset asserted during WAIT, then stray valid for the aborted fetch.
        advance("pre_rst", SEQ, 1'b0, 32'h0, 32'h4);
        step();
        rstn = 1'b0;
        #1;
        check("ar_pc", pc, 32'h0);
        check("ar_instr", instr, 32'h0);
        check("ar_req", {31'h0, imem_req}, 32'h0);
        check("ar_ivalid", {31'h0, instr_valid}, 32'h0);
        check("ar_err", {31'h0, pc_err}, 32'h0);
        step();
        rstn       = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_valid = 1'b0;
        check("stray_err", {31'h0, pc_err}, 32'h1);
        check("stray_instr", instr, 32'h0);
        fetch("refetch", 32'h2008_0005, 1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
